// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use, branch redirect and
// mul/div occupancy, producing per-register write-enable/flush plus saturating stats.
module pipeline_hazard_ctrl #(
    parameter int MD_CYCLES = 4,
    parameter int PERF_W    = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_md_use,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              ex_branch_taken,
    input  logic              ex_md_start,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              idex_we,
    output logic              exmem_we,
    output logic              memwb_we,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              md_busy,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);
    typedef enum logic {IDLE, BUSY} md_state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES);

    md_state_t  state, state_nxt;
    logic [3:0] md_cnt, md_cnt_nxt;
    logic       lu, mh, flush_sel, stall_sel;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            md_cnt <= 4'd0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // A start seen while BUSY (including the final cycle) is dropped, never reloaded.
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        case (state)
            IDLE: begin
                if (ex_md_start) begin
                    md_cnt_nxt = MD_LOAD;
                    state_nxt  = BUSY;
                end
            end
            BUSY: begin
                md_cnt_nxt = md_cnt - 4'd1;
                if (md_cnt == 4'd1)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                md_cnt_nxt = 4'd0;
            end
        endcase
    end

    assign md_busy = (state == BUSY);

    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign mh = md_busy && id_md_use;

    // A taken branch squashes the stalled ID instruction, so it wins over any stall.
    assign flush_sel = ex_branch_taken;
    assign stall_sel = !ex_branch_taken && (lu || mh);

    assign pc_we       = !stall_sel;
    assign ifid_we     = !stall_sel;
    assign ifid_flush  = flush_sel;
    assign idex_we     = 1'b1;
    assign idex_flush  = flush_sel || stall_sel;
    assign exmem_we    = 1'b1;
    assign exmem_flush = 1'b0;
    assign memwb_we    = 1'b1;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_sel && (stall_cnt != {PERF_W{1'b1}}))
                stall_cnt <= stall_cnt + PERF_W'(1);
            if (flush_sel && (flush_cnt != {PERF_W{1'b1}}))
                flush_cnt <= flush_cnt + PERF_W'(1);
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic, all checked
// against a cycle-indexed behavioural model (busy window, saturating integer counters).
module tb_pipeline_hazard_ctrl;
    localparam int MD = 4;
    localparam int PW = 4;
    localparam int SAT = (1 << PW) - 1;

    logic          Clk = 1'b0;
    logic          Rst;
    logic [4:0]    id_rs, id_rt, ex_rd;
    logic          id_uses_rs, id_uses_rt, id_md_use, ex_mem_read, ex_branch_taken, ex_md_start;
    logic          pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic          ifid_flush, idex_flush, exmem_flush, md_busy;
    logic [PW-1:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.MD_CYCLES(MD), .PERF_W(PW)) dut (
        .Clk(Clk), .Rst(Rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_md_use(id_md_use), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_md_start(ex_md_start),
        .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
        .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .md_busy(md_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_err = 0;

    // model: md unit busy during cycles (start_cycle+1 .. start_cycle+MD)
    int cyc;
    int busy_end;
    int m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_md_use = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; ex_md_start = 1'b0;
    endtask

    task automatic model_reset();
        cyc = 0; busy_end = -1; m_stall = 0; m_flush = 0;
    endtask

    // Called just after a negedge with inputs already applied: check, advance one edge.
    task automatic tick();
        bit busy, lu, stall, br;
        #1;
        busy  = (cyc <= busy_end);
        br    = ex_branch_taken;
        lu    = ex_mem_read && ex_rd != 0 &&
                ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        stall = !br && (lu || (busy && id_md_use));
        chk("pc_we",      pc_we,      !stall);
        chk("ifid_we",    ifid_we,    !stall);
        chk("ifid_flush", ifid_flush, br);
        chk("idex_we",    idex_we,    1);
        chk("idex_flush", idex_flush, br || stall);
        chk("tail_regs",  {exmem_we, memwb_we, exmem_flush}, 3'b110);
        chk("md_busy",    md_busy,    busy);
        chk("stall_cnt",  stall_cnt,  m_stall);
        chk("flush_cnt",  flush_cnt,  m_flush);
        @(posedge Clk);
        if (br) m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
        if (stall) m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
        if (!busy && ex_md_start) busy_end = cyc + MD;
        cyc++;
        @(negedge Clk);
    endtask

    // Reset asserted mid-cycle; state must clear before any clock edge.
    task automatic async_reset();
        #2 Rst = 1'b1;
        #1;
        chk("rst_md_busy",   md_busy,   0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        model_reset();
        @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] r);
        ex_mem_read = 1'b1; ex_rd = r; id_rs = r; id_uses_rs = 1'b1;
    endtask

    initial begin
        idle_inputs();
        Rst = 1'b1;
        model_reset();
        @(negedge Clk);
        async_reset();

        // idle
        tick(); tick();

        // load-use stall, then cleared, then r0 never hazards
        load_use(5'd5); tick();
        idle_inputs(); tick();
        chk("lu_stall_cnt", stall_cnt, 1);
        load_use(5'd0); tick();
        idle_inputs(); id_rt = 5'd7; id_uses_rt = 1'b1; ex_rd = 5'd7; ex_mem_read = 1'b1; tick();

        // branch overrides a simultaneous load-use
        load_use(5'd9); ex_branch_taken = 1'b1; tick();
        idle_inputs(); tick();

        // mul/div occupancy with dependent consumer
        async_reset();
        ex_md_start = 1'b1; tick();
        ex_md_start = 1'b0; id_md_use = 1'b1;
        repeat (5) tick();
        chk("md_stall_cnt", stall_cnt, MD);
        idle_inputs();

        // start while busy (cycle 2 and last cycle) is ignored
        async_reset();
        ex_md_start = 1'b1; tick();
        ex_md_start = 1'b0; tick();
        ex_md_start = 1'b1; tick();
        ex_md_start = 1'b0; tick();
        ex_md_start = 1'b1; tick();
        ex_md_start = 1'b0; tick();
        chk("md_no_reload", md_busy, 0);

        // reset while busy
        ex_md_start = 1'b1; tick();
        ex_md_start = 1'b0; tick();
        async_reset();

        // saturation
        load_use(5'd3); repeat (20) tick();
        idle_inputs(); ex_branch_taken = 1'b1; repeat (20) tick();
        idle_inputs(); tick();
        chk("sat_stall", stall_cnt, SAT);
        chk("sat_flush", flush_cnt, SAT);

        // random traffic with occasional resets
        async_reset();
        for (int i = 0; i < 400; i++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            id_md_use       = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_md_start     = ($urandom_range(0, 3) == 0);
            if (i % 100 == 99) async_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
